// File: rtl/glyph_pkg.sv
// Shared constants and types for the text-mode glyph renderer.
package glyph_pkg;
  localparam int H_ORIGIN     = 48;
  localparam int V_ORIGIN     = 33;
  localparam int COLS         = 80;
  localparam int ROWS         = 30;
  localparam int BLINK_FRAMES = 30;
  localparam int PIPE_DEPTH   = 5;

  typedef logic [7:0] rgb332_t;

  // Per-pixel side information that travels alongside the RAM/ROM fetches.
  typedef struct packed {
    logic [2:0] xbit;
    logic [3:0] grow;
    logic       bright;
    logic       area;
    logic       cur;
  } pix_t;
endpackage

// File: rtl/blink_timer.sv
// Cursor blink timer: counts vsync falling edges and toggles the blink phase.
module blink_timer #(
  parameter int FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic phase
);
  localparam int CW = (FRAMES > 2) ? $clog2(FRAMES) : 1;

  logic          vs_q;
  logic [CW-1:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q      <= 1'b1;
      frame_cnt <= '0;
      phase     <= 1'b1;
    end else begin
      vs_q <= vsync;
      if (vs_q && !vsync) begin
        if (frame_cnt == CW'(FRAMES - 1)) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/glyph_renderer.sv
// Text-mode pixel pipeline: char RAM -> font ROM -> colour, 5 clk from counters to rgb.
module glyph_renderer
  import glyph_pkg::rgb332_t;
  import glyph_pkg::pix_t;
  import glyph_pkg::PIPE_DEPTH;
#(
  parameter int H_ORIGIN     = glyph_pkg::H_ORIGIN,
  parameter int V_ORIGIN     = glyph_pkg::V_ORIGIN,
  parameter int COLS         = glyph_pkg::COLS,
  parameter int ROWS         = glyph_pkg::ROWS,
  parameter int BLINK_FRAMES = glyph_pkg::BLINK_FRAMES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [10:0]   pixel_cnt,
  input  logic [10:0]   line_cnt,
  input  logic          bright,
  input  logic          hsync_in,
  input  logic          vsync_in,
  output logic [11:0]   char_addr,
  input  logic [7:0]    char_data,
  output logic [11:0]   font_addr,
  input  logic [7:0]    font_data,
  input  rgb332_t       fg_color,
  input  rgb332_t       bg_color,
  input  logic          cursor_en,
  input  logic [6:0]    cursor_col,
  input  logic [4:0]    cursor_row,
  output rgb332_t       rgb,
  output logic          hsync_out,
  output logic          vsync_out
);
  localparam int FONT_STG = 2;
  localparam int LAST     = PIPE_DEPTH - 1;

  logic [10:0] x, y;
  logic [6:0]  col;
  logic [4:0]  row;
  logic [2:0]  xbit;
  logic [3:0]  grow;
  logic [11:0] addr_sum;
  logic        area, cur, phase;
  logic        unused_bits;

  assign x    = pixel_cnt - 11'(H_ORIGIN);
  assign y    = line_cnt - 11'(V_ORIGIN);
  assign col  = x[9:3];
  assign xbit = x[2:0];
  assign row  = y[8:4];
  assign grow = y[3:0];
  assign unused_bits = ^{x[10], y[10:9]};

  // The counter-origin tests mask the wraparound of x/y below the origin.
  assign area = (pixel_cnt >= 11'(H_ORIGIN)) && (line_cnt >= 11'(V_ORIGIN)) &&
                (col < 7'(COLS)) && (row < 5'(ROWS));

  // row*80 as row*64 + row*16
  assign addr_sum = 12'({row, 6'b0}) + 12'({row, 4'b0}) + 12'(col);

  assign cur = cursor_en && phase && (col == cursor_col) && (row == cursor_row) &&
               (grow >= 4'd14);

  blink_timer #(.FRAMES(BLINK_FRAMES)) u_blink (
    .clk   (clk),
    .rst_n (rst_n),
    .vsync (vsync_in),
    .phase (phase)
  );

  pix_t [LAST:1]   pipe;
  logic [LAST:0]   hs_d, vs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_addr <= '0;
      font_addr <= '0;
      rgb       <= '0;
      pipe      <= '0;
      hs_d      <= '1;
      vs_d      <= '1;
    end else begin
      char_addr <= area ? addr_sum : 12'd0;
      pipe[1]   <= {xbit, grow, bright, area, cur};
      for (int i = 2; i <= LAST; i++) pipe[i] <= pipe[i-1];
      font_addr <= {char_data, pipe[FONT_STG].grow};
      hs_d      <= {hs_d[LAST-1:0], hsync_in};
      vs_d      <= {vs_d[LAST-1:0], vsync_in};
      if (!pipe[LAST].bright)
        rgb <= 8'h00;
      else if (!pipe[LAST].area)
        rgb <= bg_color;
      else if (font_data[3'd7 - pipe[LAST].xbit] || pipe[LAST].cur)
        rgb <= fg_color;
      else
        rgb <= bg_color;
    end
  end

  assign hsync_out = hs_d[LAST];
  assign vsync_out = vs_d[LAST];
endmodule

// File: tb/tb_glyph_renderer.sv
// Scoreboard bench for glyph_renderer with an arithmetic reference model.
module tb_glyph_renderer;
  import glyph_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] pixel_cnt = '0, line_cnt = '0;
  logic        bright = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic [11:0] char_addr, font_addr;
  logic [7:0]  char_data = '0, font_data = '0;
  logic [7:0]  fg_color, bg_color, rgb;
  logic        cursor_en = 1'b1;
  logic [6:0]  cursor_col = 7'd3;
  logic [4:0]  cursor_row = 5'd2;
  logic        hsync_out, vsync_out;

  glyph_renderer dut (
    .clk(clk), .rst_n(rst_n), .pixel_cnt(pixel_cnt), .line_cnt(line_cnt),
    .bright(bright), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .char_addr(char_addr), .char_data(char_data), .font_addr(font_addr),
    .font_data(font_data), .fg_color(fg_color), .bg_color(bg_color),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:4095];
  logic [7:0] rom [0:4095];
  always @(posedge clk) begin
    char_data <= ram[char_addr];
    font_data <= rom[font_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [11:0] v; } chk_t;
  chk_t q_ca[$], q_fa[$], q_px[$];
  chk_t e_m;
  int   n_vec = 0, n_err = 0;
  int   falls = 0;
  logic prev_vs = 1'b1;

  task automatic cmp(input string nm, input int due, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (due != cyc || got !== exp) begin
      n_err++;
      $display("FAIL %s cyc %0d (due %0d): got %h, expected %h", nm, cyc, due, got, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    while (q_ca.size() > 0 && q_ca[0].due <= cyc) begin
      e_m = q_ca.pop_front(); cmp("char_addr", e_m.due, char_addr, e_m.v);
    end
    while (q_fa.size() > 0 && q_fa[0].due <= cyc) begin
      e_m = q_fa.pop_front(); cmp("font_addr", e_m.due, font_addr, e_m.v);
    end
    while (q_px.size() > 0 && q_px[0].due <= cyc) begin
      e_m = q_px.pop_front(); cmp("rgb_sync", e_m.due, {2'b00, hsync_out, vsync_out, rgb}, e_m.v);
    end
  end

  // Reference: screen-level arithmetic on the cell grid and memory contents.
  function automatic void model(input int p, input int l, input logic br, input logic hs,
                                input logic vs, output logic [11:0] ca, output logic [11:0] fa,
                                output logic [11:0] px);
    int x, y, col, row, xb, gr;
    bit area, cur, pix;
    logic [7:0] code, fr, c;
    x = (p - H_ORIGIN) & 2047;  y = (l - V_ORIGIN) & 2047;
    col = (x >> 3) & 127;  row = (y >> 4) & 31;  xb = x & 7;  gr = y & 15;
    area = p >= H_ORIGIN && l >= V_ORIGIN && col < COLS && row < ROWS;
    ca = area ? 12'(row * COLS + col) : 12'd0;
    code = ram[ca];
    fa = {code, 4'(gr)};
    fr = rom[fa];
    pix = fr[7 - xb];
    cur = cursor_en && ((falls / BLINK_FRAMES) % 2 == 0) && col == int'(cursor_col) &&
          row == int'(cursor_row) && gr >= 14;
    c = !br ? 8'h00 : (!area ? bg_color : ((pix || cur) ? fg_color : bg_color));
    px = {2'b00, hs, vs, c};
  endfunction

  task automatic apply(input int p, input int l, input logic br, input logic hs, input logic vs);
    logic [11:0] ca, fa, px;
    pixel_cnt = 11'(p); line_cnt = 11'(l); bright = br; hsync_in = hs; vsync_in = vs;
    model(p, l, br, hs, vs, ca, fa, px);
    q_ca.push_back('{cyc + 1, ca});
    q_fa.push_back('{cyc + 3, fa});
    q_px.push_back('{cyc + 5, px});
    if (prev_vs && !vs) falls++;
    prev_vs = vs;
  endtask

  task automatic drive(input int p, input int l, input logic br, input logic hs, input logic vs);
    @(negedge clk);
    apply(p, l, br, hs, vs);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (rgb !== 8'h00 || char_addr !== 12'd0 || font_addr !== 12'd0 ||
        hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
      n_err++;
      $display("FAIL reset: got rgb=%h ca=%h fa=%h hs=%b vs=%b, expected 00 000 000 1 1",
               rgb, char_addr, font_addr, hsync_out, vsync_out);
    end
    q_ca.delete(); q_fa.delete(); q_px.delete();
    falls = 0; prev_vs = 1'b1;
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) q_px.push_back('{cyc + i, 12'h300});
    apply(48 + 8, 33, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 8'($urandom);
      rom[i] = 8'($urandom);
    end
    ram[1] = 8'h41;   rom[12'h410] = 8'h80;
    ram[0] = 8'h22;   rom[12'h220] = 8'hFF;
    ram[2 * COLS + 3] = 8'h33;  rom[12'h33E] = 8'h00;  rom[12'h33D] = 8'h00;
    fg_color = 8'($urandom);
    bg_color = fg_color ^ 8'h5A;

    do_reset(3);

    // Glyph fetch and neighbouring column
    drive(56, 33, 1, 1, 1);
    drive(57, 33, 1, 1, 1);
    // Last cell and first column past the text area
    drive(48 + 632 + 7, 33 + 464 + 15, 1, 1, 1);
    drive(48 + 640, 33 + 464 + 15, 1, 1, 1);
    drive(47, 32, 1, 1, 1);
    // Blanking over a solid glyph row, then an hsync pulse
    drive(48, 33, 0, 1, 1);
    drive(48, 33, 1, 1, 1);
    for (int i = 0; i < 8; i++) drive(100 + i, 40, 1, (i >= 2 && i < 5) ? 1'b0 : 1'b1, 1);

    // Mid-line reset, then cursor blink across 64 frames
    for (int i = 0; i < 5; i++) drive(60 + i, 50, 1, 1, 1);
    do_reset(2);
    for (int f = 0; f < 64; f++) begin
      drive(10, 5, 0, 1, 0);
      drive(11, 5, 0, 1, 1);
      drive(48 + 24 + (f % 8), 33 + 32 + 14, 1, 1, 1);
      drive(48 + 24 + 8, 33 + 32 + 14, 1, 1, 1);
      drive(48 + 24 + (f % 8), 33 + 32 + 13, 1, 1, 1);
    end

    // Random pixels every clock
    for (int i = 0; i < 1500; i++) begin
      cursor_en = ($urandom % 4) != 0;
      if ($urandom % 4 == 0) begin
        cursor_col = 7'($urandom_range(0, 79));
        cursor_row = 5'($urandom_range(0, 29));
      end
      drive($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom % 6 != 0),
            1'($urandom % 8 != 0), 1'($urandom % 16 != 0));
    end
    // Counters held for 4 clk each, as with a divided pixel clock
    for (int i = 0; i < 100; i++) begin
      int p, l;
      logic br, hs, vs;
      p = $urandom_range(40, 700); l = $urandom_range(30, 520);
      br = 1'($urandom % 5 != 0); hs = 1'($urandom % 8 != 0); vs = 1'($urandom % 12 != 0);
      repeat (4) drive(p, l, br, hs, vs);
    end

    repeat (8) @(negedge clk);
    n_vec++;
    if (q_ca.size() + q_fa.size() + q_px.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, expected 0",
               q_ca.size() + q_fa.size() + q_px.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
